struct_field_packer: RTL
========================

# struct_field_packer

Two-channel assembler that feeds packed-struct consumers. It accepts `field0` and `field1` values on independent valid/ready channels, in any order and with any skew. It holds each field in a one-entry slot, then emits one packed word per matched pair, with `field0` in the MSBs and `field1` in the LSBs. This is the layout a `struct packed { field0; field1; }` consumer expects, so its slice `[W0+W1-1:W1]` equals `field0` and `[W1-1:0]` equals `field1`.

## Interface
Parameters:
- `FIELD0_WIDTH`, default 4: width W0 of field0; must be ≥1.
- `FIELD1_WIDTH`, default 4: width W1 of field1; must be ≥1.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `f0_valid`  in  1  field0 offer.
- `f0_ready`  out  1  field0 slot can accept.
- `f0_data`  in  W0  field0 value.
- `f1_valid`  in  1  field1 offer.
- `f1_ready`  out  1  field1 slot can accept.
- `f1_data`  in  W1  field1 value.
- `out_valid`  out  1  packed word available.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  W0+W1  packed word `{field0, field1}`.
- `word_count`  out  16  number of completed output handshakes, modulo 2^16.

## Operation
- Slot state: per field, a `full` bit plus a data register (`s0`, `s1`). Each slot is EMPTY or FULL.
- Handshakes:
  - Field handshake: `fX_fire = fX_valid & fX_ready`.
  - Output handshake: `out_fire = out_valid & out_ready`.
- `out_free = !out_valid | out_ready`.
- `combine = s0_full & s1_full & out_free`.
- Ready rule: `fX_ready = !rst & (!sX_full | combine)`. It is combinational and may depend on `out_ready`. No slot ever overwrites unconsumed data.
- On `combine`:
  - `out_data <= {s0, s1}` and `out_valid <= 1`.
  - Both slots are released.
  - If `fX_fire` occurs in the same cycle, slot X refills with the new data and stays FULL.
- On `fX_fire` without `combine`: slot X becomes FULL with `fX_data`.
- On `out_fire` without `combine`: `out_valid <= 0`. `out_data` holds its last value.
- `out_data` and `out_valid` are stable while `out_valid & !out_ready`.
- Fields are paired strictly in arrival order per channel. No reordering; no field is dropped.
- `word_count` increments by 1 on each `out_fire` and wraps from 0xFFFF to 0x0000.
- Width rule: `out_data[W0+W1-1:W1] = field0` and `out_data[W1-1:0] = field1`, with no extension or truncation.

## Timing
- Reset values, applied at the edge while `rst` is high:
  - slots EMPTY
  - `out_valid = 0`
  - `out_data = 0`
  - `word_count = 0`
- While `rst` is high, `f0_ready = f1_ready = 0`.
- Reset asserted mid-operation discards held fields and any pending output word, with no partial emission.
- The first cycle after `rst` deasserts: `f0_ready = f1_ready = 1`.
- Latency: both fields accepted in cycle c → slots FULL in c+1 → `combine` in c+1 (output free) → `out_valid = 1` in c+2.
- If one field arrives k cycles after the other, `out_valid` rises 2 cycles after the later field's handshake.
- Throughput: with `out_ready` held at 1 and both channels valid every cycle, one word per cycle in steady state.
- Backpressure: with `out_ready = 0` and `out_valid = 1`, at most one further field per channel is accepted; both readies then stay 0 until `out_fire`.
- Simultaneous `out_fire`, `combine` and both `fX_fire` in one cycle: the new word is loaded, slots are refilled, and `word_count` increments once.

## Test plan
Bench parameters: W0=6, W1=5.
1. Reset then a single pair: f0=0x2A and f1=0x13 in the same cycle, `out_ready = 1` → `out_valid` 2 cycles later with `out_data = 0x553` (field0 slice 0x2A, field1 slice 0x13); `word_count = 1` after the handshake.
2. Skewed arrival: f1=0x1F at cycle 0, f0=0x00 at cycle 3 → `f1_ready = 0` during cycles 1–3; `out_data = 0x01F` at cycle 5.
3. Backpressure: `out_ready = 0` for 10 cycles while pairs (0x01,0x01), (0x02,0x02), (0x03,0x03) are offered → the first word is held stable, the second pair sits in the slots, and both readies drop. On release, words 0x021, 0x042, 0x063 emerge in order.
4. Streaming: 100 random pairs offered back to back, `out_ready = 1` → 100 words at 1/cycle after fill, in order, with matching slices.
5. Wrap: 65,537 pairs → `word_count` reads 0x0001.
6. Mid-operation reset: f0 held in its slot, `rst` pulsed for 1 cycle → `out_valid` stays 0, `word_count = 0`. A subsequent pair (0x15, 0x0A) yields `out_data = 0x2AA`; the stale field0 never appears.

Source files
------------

// File: rtl/struct_field_packer.sv
// Two-channel field assembler: pairs field0/field1 arrivals in order and emits
// one packed word {field0, field1} per matched pair over a valid/ready output.
module struct_field_packer #(
    parameter int FIELD0_WIDTH = 4,
    parameter int FIELD1_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 f0_valid,
    output logic                                 f0_ready,
    input  logic [FIELD0_WIDTH-1:0]              f0_data,
    input  logic                                 f1_valid,
    output logic                                 f1_ready,
    input  logic [FIELD1_WIDTH-1:0]              f1_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [FIELD0_WIDTH+FIELD1_WIDTH-1:0] out_data,
    output logic [15:0]                          word_count
);

    localparam int OUT_WIDTH = FIELD0_WIDTH + FIELD1_WIDTH;

    logic                    s0_full_r;
    logic                    s1_full_r;
    logic [FIELD0_WIDTH-1:0] s0_r;
    logic [FIELD1_WIDTH-1:0] s1_r;
    logic                    out_valid_r;
    logic [OUT_WIDTH-1:0]    out_data_r;
    logic [15:0]             word_count_r;

    logic out_free_s;
    logic combine_s;
    logic f0_ready_s;
    logic f1_ready_s;
    logic f0_fire_s;
    logic f1_fire_s;
    logic out_fire_s;

    // Handshake decode; a full slot may accept again in the cycle it is drained.
    always_comb begin
        out_free_s = !out_valid_r || out_ready;
        combine_s  = s0_full_r && s1_full_r && out_free_s;
        f0_ready_s = !rst && (!s0_full_r || combine_s);
        f1_ready_s = !rst && (!s1_full_r || combine_s);
        f0_fire_s  = f0_valid && f0_ready_s;
        f1_fire_s  = f1_valid && f1_ready_s;
        out_fire_s = out_valid_r && out_ready;
    end

    assign f0_ready   = f0_ready_s;
    assign f1_ready   = f1_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign word_count = word_count_r;

    // Field0 slot: a fresh arrival wins over release so same-cycle refill stays FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_full_r <= 1'b0;
            s0_r      <= '0;
        end else if (f0_fire_s) begin
            s0_full_r <= 1'b1;
            s0_r      <= f0_data;
        end else if (combine_s) begin
            s0_full_r <= 1'b0;
        end else begin
            s0_full_r <= s0_full_r;
        end
    end

    // Field1 slot, same policy as field0.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_full_r <= 1'b0;
            s1_r      <= '0;
        end else if (f1_fire_s) begin
            s1_full_r <= 1'b1;
            s1_r      <= f1_data;
        end else if (combine_s) begin
            s1_full_r <= 1'b0;
        end else begin
            s1_full_r <= s1_full_r;
        end
    end

    // Output register: loads a new word on combine, otherwise clears valid once taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (combine_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= {s0_r, s1_r};
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Completed-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_r <= 16'd0;
        end else if (out_fire_s) begin
            word_count_r <= word_count_r + 16'd1;
        end else begin
            word_count_r <= word_count_r;
        end
    end

endmodule
